pc_sequencer: RTL and testbench

//  Program-counter controller for the MAP core. Computes the next 8-bit PC every enabled cycle:

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/pc_return_stack.sv | 50 +++++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the MAP program-counter sequencer.
// Covers opcodes, fault codes and FSM states.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_NEXT   = 3'd0,
        OP_BR_REL = 3'd1,
        OP_JMP    = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_HOLD   = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        FC_NONE      = 2'd0,
        FC_OVERFLOW  = 2'd1,
        FC_UNDERFLOW = 2'd2
    } fault_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address stack used by pc_sequencer for CALL/RET.
// The caller guarantees that push and pop are never asserted together.
module pc_return_stack #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH) + 1,
    localparam int IDX_W      = $clog2(STACK_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [PC_W-1:0]    push_data_i,
    output logic [PC_W-1:0]    top_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [PC_W-1:0]    mem_q [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;

    assign wr_idx = depth_q[IDX_W-1:0];
    assign rd_idx = wr_idx - IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
        end else if (push_i) begin
            depth_q <= depth_q + DEPTH_W'(1);
        end else if (pop_i) begin
            depth_q <= depth_q - DEPTH_W'(1);
        end
    end

    // Contents are meaningless after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign top_o   = mem_q[rd_idx];
    assign depth_o = depth_q;
    assign full_o  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty_o = (depth_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: sequential step, relative branch, jump, call/return,
// with a hardware return stack and a sticky overflow/underflow fault state.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W        = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    localparam int             DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               iEn,
    input  logic [2:0]         iOp,
    input  logic               iCond,
    input  logic [PC_W-1:0]    iOffset,
    input  logic [PC_W-1:0]    iTarget,
    input  logic               iClrFault,
    output logic [PC_W-1:0]    oPC,
    output logic [PC_W-1:0]    oPCNext,
    output logic               oValid,
    output logic [DEPTH_W-1:0] oDepth,
    output logic               oStackFull,
    output logic               oStackEmpty,
    output logic               oFault,
    output logic [1:0]         oFaultCode,
    output logic [1:0]         oState
);

    state_e          state_q;
    fault_e          code_q;
    fault_e          fault_req;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] add_b;
    logic [PC_W-1:0] sum;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] top;
    logic            full;
    logic            empty;

    pc_return_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (sum),
        .top_o       (top),
        .depth_o     (oDepth),
        .full_o      (full),
        .empty_o     (empty)
    );

    // One adder serves step, taken branch and the CALL return address (PC+1).
    always_comb begin
        add_b     = ((iOp == OP_BR_REL) && iCond) ? iOffset : PC_W'(1);
        sum       = pc_q + add_b;
        pc_d      = pc_q;
        push      = 1'b0;
        pop       = 1'b0;
        fault_req = FC_NONE;
        if ((state_q == ST_RUN) && iEn) begin
            case (iOp)
                OP_NEXT, OP_BR_REL: pc_d = sum;
                OP_JMP:             pc_d = iTarget;
                OP_CALL: begin
                    if (full) begin
                        fault_req = FC_OVERFLOW;
                    end else begin
                        push = 1'b1;
                        pc_d = iTarget;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        fault_req = FC_UNDERFLOW;
                    end else begin
                        pop  = 1'b1;
                        pc_d = top;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            code_q  <= FC_NONE;
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    pc_q <= pc_d;
                    if (fault_req != FC_NONE) begin
                        state_q <= ST_FAULT;
                        code_q  <= fault_req;
                    end
                end
                ST_FAULT: begin
                    if (iClrFault) begin
                        state_q <= ST_RUN;
                        code_q  <= FC_NONE;
                    end
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    assign oPC         = pc_q;
    assign oPCNext     = pc_d;
    assign oValid      = (state_q == ST_RUN);
    assign oFault      = (state_q == ST_FAULT);
    assign oFaultCode  = code_q;
    assign oStackFull  = full;
    assign oStackEmpty = empty;
    assign oState      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a reference model and expected-value queue.
module tb_pc_sequencer;

    localparam logic [2:0] NXT = 3'd0, BRR = 3'd1, JMP = 3'd2, CAL = 3'd3, RET = 3'd4, HLD = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       iEn, iCond, iClrFault;
    logic [2:0] iOp;
    logic [7:0] iOffset, iTarget;
    logic [7:0] oPC, oPCNext;
    logic       oValid, oStackFull, oStackEmpty, oFault;
    logic [2:0] oDepth;
    logic [1:0] oFaultCode, oState;

    pc_sequencer dut (
        .clk (clk), .rst (rst), .iEn (iEn), .iOp (iOp), .iCond (iCond),
        .iOffset (iOffset), .iTarget (iTarget), .iClrFault (iClrFault),
        .oPC (oPC), .oPCNext (oPCNext), .oValid (oValid), .oDepth (oDepth),
        .oStackFull (oStackFull), .oStackEmpty (oStackEmpty), .oFault (oFault),
        .oFaultCode (oFaultCode), .oState (oState)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [16:0] exp_q[$];

    // Reference model: 0 BOOT, 1 RUN, 2 FAULT
    int          m_state;
    logic [7:0]  m_pc;
    logic [1:0]  m_code;
    logic [7:0]  m_stk[$];

    function automatic logic [16:0] m_word();
        return {m_pc, 3'(m_stk.size()), (m_state == 1), (m_state == 2), m_code,
                (m_stk.size() == 4), (m_stk.size() == 0)};
    endfunction

    function automatic logic [16:0] dut_word();
        return {oPC, oDepth, oValid, oFault, oFaultCode, oStackFull, oStackEmpty};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pc    = 8'h00;
        m_code  = 2'd0;
        m_stk.delete();
    endtask

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic en, input logic [2:0] op,
                        input logic cond, input logic [7:0] off, input logic [7:0] tgt,
                        input logic clr);
        logic [7:0] nxt;
        int         ns;
        logic [1:0] code;
        iEn = en; iOp = op; iCond = cond; iOffset = off; iTarget = tgt; iClrFault = clr;
        nxt = m_pc; ns = m_state; code = m_code;
        case (m_state)
            0: ns = 1;
            2: if (clr) begin ns = 1; code = 2'd0; end
            default: if (en) begin
                case (op)
                    NXT: nxt = m_pc + 8'd1;
                    BRR: nxt = cond ? m_pc + off : m_pc + 8'd1;
                    JMP: nxt = tgt;
                    CAL: if (m_stk.size() == 4) begin ns = 2; code = 2'd1; end
                         else begin m_stk.push_back(m_pc + 8'd1); nxt = tgt; end
                    RET: if (m_stk.size() == 0) begin ns = 2; code = 2'd2; end
                         else nxt = m_stk.pop_back();
                    default: ;
                endcase
            end
        endcase
        #1;
        check({tag, "/pcnext"}, 17'(oPCNext), 17'(nxt));
        m_pc = nxt; m_state = ns; m_code = code;
        exp_q.push_back(m_word());
        @(posedge clk);
        #1;
        check(tag, dut_word(), exp_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; iEn = 1'b0; iOp = HLD; iCond = 1'b0;
        iOffset = 8'h00; iTarget = 8'h00; iClrFault = 1'b0;
        model_reset();
        #1;
        check("reset", dut_word(), m_word());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Boot cycle, then sequential stepping
        step("boot",  1, NXT, 0, 8'h00, 8'h00, 0);
        step("next1", 1, NXT, 0, 8'h00, 8'h00, 0);
        step("next2", 1, NXT, 0, 8'h00, 8'h00, 0);
        step("next3", 1, NXT, 0, 8'h00, 8'h00, 0);
        step("en0",   0, JMP, 0, 8'h00, 8'h77, 0);
        step("hold",  1, HLD, 0, 8'h00, 8'h77, 0);
        step("rsvd7", 1, 3'd7, 1, 8'h05, 8'h77, 0);

        // Relative branches and wrap-around
        step("jmp02a", 1, JMP, 0, 8'h00, 8'h02, 0);
        step("br_tkn", 1, BRR, 1, 8'hFC, 8'h00, 0);
        step("jmp02b", 1, JMP, 0, 8'h00, 8'h02, 0);
        step("br_not", 1, BRR, 0, 8'hFC, 8'h00, 0);
        step("br_fwd", 1, BRR, 1, 8'h10, 8'h00, 0);
        step("jmpFF",  1, JMP, 0, 8'h00, 8'hFF, 0);
        step("wrap",   1, NXT, 0, 8'h00, 8'h00, 0);

        // Call / return
        step("jmp10",  1, JMP, 0, 8'h00, 8'h10, 0);
        step("call40", 1, CAL, 0, 8'h00, 8'h40, 0);
        step("ret11",  1, RET, 0, 8'h00, 8'h00, 0);
        step("jmpFF2", 1, JMP, 0, 8'h00, 8'hFF, 0);
        step("callFF", 1, CAL, 0, 8'h00, 8'h05, 0);
        step("ret00",  1, RET, 0, 8'h00, 8'h00, 0);

        // Overflow, clear, unwind
        step("jmp20",  1, JMP, 0, 8'h00, 8'h20, 0);
        step("call1",  1, CAL, 0, 8'h00, 8'h30, 0);
        step("call2",  1, CAL, 0, 8'h00, 8'h50, 0);
        step("call3",  1, CAL, 0, 8'h00, 8'h70, 0);
        step("call4",  1, CAL, 0, 8'h00, 8'h90, 0);
        step("ovf",    1, CAL, 0, 8'h00, 8'hA0, 0);
        step("f_en",   1, JMP, 0, 8'h00, 8'h33, 0);
        step("clr1",   1, NXT, 0, 8'h00, 8'h00, 1);
        step("ret_a",  1, RET, 0, 8'h00, 8'h00, 0);
        step("ret_b",  1, RET, 0, 8'h00, 8'h00, 0);
        step("ret_c",  1, RET, 0, 8'h00, 8'h00, 0);
        step("ret_d",  1, RET, 0, 8'h00, 8'h00, 0);

        // Underflow, iEn ignored while faulted
        step("unf",    1, RET, 0, 8'h00, 8'h00, 0);
        step("f_en1",  1, NXT, 0, 8'h00, 8'h00, 0);
        step("f_en2",  1, JMP, 0, 8'h00, 8'h99, 0);
        step("clr2",   0, NXT, 0, 8'h00, 8'h00, 1);
        step("clr_ig", 1, NXT, 0, 8'h00, 8'h00, 1);

        // Asynchronous reset in the middle of a call sequence
        step("callr1", 1, CAL, 0, 8'h00, 8'h60, 0);
        step("callr2", 1, CAL, 0, 8'h00, 8'h70, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_async", dut_word(), m_word());
        @(negedge clk);
        rst = 1'b0;
        step("boot2",  1, NXT, 0, 8'h00, 8'h00, 0);
        step("next4",  1, NXT, 0, 8'h00, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
